// File: rtl/flash_pkg.sv
// Shared definitions for the on-chip SPI NOR flash responder:
// command opcodes and the state encoding used by flashNavigator.
package flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    typedef logic [2:0] flash_state_t;

    localparam flash_state_t ST_IDLE   = 3'd0;
    localparam flash_state_t ST_CMD    = 3'd1;
    localparam flash_state_t ST_ADDR   = 3'd2;
    localparam flash_state_t ST_RDATA  = 3'd3;
    localparam flash_state_t ST_PDATA  = 3'd4;
    localparam flash_state_t ST_STATUS = 3'd5;
    localparam flash_state_t ST_ID     = 3'd6;
    localparam flash_state_t ST_IGNORE = 3'd7;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises SCLK/MOSI/CS into the clk domain and produces
// single-cycle SCLK rise and fall pulses.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_n_i,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s,
    output logic cs_n_s
);
    import flash_pkg::*;

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [SYNC_STAGES-1:0] cs_n_q, cs_n_d;
    logic                   sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk_i};
        mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi_i};
        cs_n_d      = {cs_n_q[SYNC_STAGES-2:0], cs_n_i};
        sclk_prev_d = sclk_q[SYNC_STAGES-1];
    end

    // CS resets deasserted so the responder comes up idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= '0;
            mosi_q      <= '0;
            cs_n_q      <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR emulator over an internal byte RAM,
// with a backdoor preload port usable while the bus is idle.
module spi_flash_responder #(
    parameter int          ADDR_BITS   = 12,
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] JEDEC_ID    = 24'h856015
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flashClk,
    input  logic                 flashMosi,
    input  logic                 flashCs,
    output logic                 flashMiso,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_wdata,
    output logic                 busy,
    output logic                 wel
);
    import flash_pkg::*;

    logic sclk_rise, sclk_fall, mosi_s, cs_n_s;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sclk_i   (flashClk),
        .mosi_i   (flashMosi),
        .cs_n_i   (flashCs),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .mosi_s   (mosi_s),
        .cs_n_s   (cs_n_s)
    );

    flash_state_t         state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 prog_q, prog_d;
    logic                 wel_q, wel_d;
    logic [7:0]           tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic [1:0]           id_idx_q, id_idx_d;

    logic [7:0]           ram [0:(2**ADDR_BITS)-1];
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [7:0]           ram_wdata;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           rd_data;

    logic [7:0]           byte_in;
    logic [ADDR_BITS-1:0] addr_in, addr_inc, page_inc;
    logic                 byte_done;

    always_comb begin
        byte_in      = {shift_q[6:0], mosi_s};
        addr_in      = {addr_q[ADDR_BITS-2:0], mosi_s};
        addr_inc     = addr_q + ADDR_BITS'(1);
        page_inc     = addr_q;
        page_inc[7:0] = addr_q[7:0] + 8'd1;
        byte_done    = sclk_rise && (bit_cnt_q == 5'd7);
        // Read port sees the fully shifted address on the last address bit
        rd_addr      = (state_q == ST_ADDR) ? addr_in : addr_inc;
        rd_data      = ram[rd_addr];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        prog_d    = prog_q;
        wel_d     = wel_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        id_idx_d  = id_idx_q;
        ram_we    = 1'b0;
        ram_waddr = mem_addr;
        ram_wdata = mem_wdata;

        if (state_q != ST_IDLE && cs_n_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            miso_d    = 1'b0;
            tx_d      = 8'h00;
            prog_d    = 1'b0;
            if (prog_q && (state_q == ST_ADDR || state_q == ST_PDATA))
                wel_d = 1'b0;
        end else begin
            if (state_q != ST_IDLE) begin
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    shift_d   = byte_in;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    ram_we = mem_we;
                    if (!cs_n_s) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        bit_cnt_d = 5'd0;
                        state_d   = ST_IGNORE;
                        case (byte_in)
                            CMD_READ: begin
                                state_d = ST_ADDR;
                                prog_d  = 1'b0;
                            end
                            CMD_PP: begin
                                if (wel_q) begin
                                    state_d = ST_ADDR;
                                    prog_d  = 1'b1;
                                end
                            end
                            CMD_WREN: wel_d = 1'b1;
                            CMD_WRDI: wel_d = 1'b0;
                            CMD_RDSR: begin
                                state_d = ST_STATUS;
                                tx_d    = {6'b0, wel_q, 1'b0};
                            end
                            CMD_RDID: begin
                                state_d  = ST_ID;
                                tx_d     = JEDEC_ID[23:16];
                                id_idx_d = 2'd1;
                            end
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d = addr_in;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            if (prog_q) begin
                                state_d = ST_PDATA;
                            end else begin
                                state_d = ST_RDATA;
                                tx_d    = rd_data;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (byte_done) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = addr_inc;
                        tx_d      = rd_data;
                    end
                end
                ST_PDATA: begin
                    if (byte_done) begin
                        bit_cnt_d = 5'd0;
                        ram_we    = 1'b1;
                        ram_waddr = addr_q;
                        ram_wdata = byte_in;
                        addr_d    = page_inc;
                    end
                end
                ST_STATUS: begin
                    if (byte_done) begin
                        bit_cnt_d = 5'd0;
                        tx_d      = {6'b0, wel_q, 1'b0};
                    end
                end
                ST_ID: begin
                    if (byte_done) begin
                        bit_cnt_d = 5'd0;
                        case (id_idx_q)
                            2'd1:    tx_d = JEDEC_ID[15:8];
                            2'd2:    tx_d = JEDEC_ID[7:0];
                            default: tx_d = 8'h00;
                        endcase
                        if (id_idx_q != 2'd3)
                            id_idx_d = id_idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 5'd0;
            shift_q   <= 8'h00;
            addr_q    <= '0;
            prog_q    <= 1'b0;
            wel_q     <= 1'b0;
            tx_q      <= 8'h00;
            miso_q    <= 1'b0;
            id_idx_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            prog_q    <= prog_d;
            wel_q     <= wel_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            id_idx_q  <= id_idx_d;
        end
    end

    // Contents survive reset so a preload is not lost
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    assign flashMiso = miso_q;
    assign busy      = ~cs_n_s;
    assign wel       = wel_q;

endmodule
